mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the miniRV instruction-fetch path (read-only) and the load/store data path (read/write with byte strobes). It arbitrates round-robin between the two requesters and serialises accesses, one transaction in flight at a time. It sequences each memory access and returns a one-cycle response pulse to the originating port. It sits between the CPU core's fetch/LSU stages and the shared memory model.

Parameters:
- LATENCY, 1, memory read latency in cycles, counted from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..8.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  ADDR_W  fetch byte address
- i_resp_valid  out  1  fetch data-return pulse
- i_resp_data  out  32  fetched word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data byte address
- d_req_we  in  1  1 = store, 0 = load
- d_req_wstrb  in  4  byte strobes for a store
- d_req_wdata  in  32  store data
- d_resp_valid  out  1  load data or store-ack pulse
- d_resp_data  out  32  load word; 0 for store acks
- mem_en  out  1  memory access strobe
- mem_wstrb  out  4  memory byte write enables; 0000 for reads
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; all ready, resp_valid and mem_en outputs 0; mem_wstrb 0; prio = DATA; resp_data 0; counter 0.
- Reset mid-transaction aborts the transaction. No response is produced, and mem_rdata is ignored until a new issue.
- States:
  - IDLE: ready may assert; on accept go to ISSUE.
  - ISSUE: one cycle; mem_en=1 with the latched addr/wstrb/wdata; counter is loaded with LATENCY.
  - WAIT: counter decrements; the cycle in which the counter reaches 1 is the rdata-valid cycle. Capture mem_rdata into the port's resp_data register, then go to IDLE.
- Response:
  - resp_valid for the captured port is high for exactly one cycle, the first IDLE cycle after WAIT.
  - A new request may be accepted in that same cycle.
- Timing: accept at cycle T → mem_en at T+1 → rdata valid at T+1+LATENCY → resp_valid at T+2+LATENCY. The next accept is possible at T+2+LATENCY.
- Ready rules:
  - ready is combinational: asserted only in IDLE and only for the arbitration winner.
  - Acceptance is valid & ready. Requesters hold valid/addr/data stable until accepted.
- Arbitration:
  - Only one port valid: that port wins.
  - Both ports valid: the port named by prio wins.
  - On every accept, prio is set to the other port.
  - The first contended cycle after reset goes to data.
- Store: mem_wstrb = latched d_req_wstrb and mem_wdata = latched d_req_wdata during ISSUE. The store still runs the full WAIT period. d_resp_valid pulses with d_resp_data = 0.
- Load/fetch: mem_wstrb = 0000 during ISSUE.
- Response data hold: i_resp_data and d_resp_data hold their last captured values outside resp_valid.
- Outside ISSUE: mem_en = 0, mem_wstrb = 0000, mem_addr and mem_wdata hold their last values.
- Store with wstrb = 0000: legal; mem_en still pulses, and the ack is returned.
- Address: bits [1:0] are dropped on mem_addr and not checked; byte lane selection belongs to the LSU.
- Requests arriving during ISSUE/WAIT see ready = 0. No queueing, no loss.

Decomposition:
- miniRV_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - port id constants PORT_I = 1'b0, PORT_D = 1'b1
  - constant WSTRB_NONE = 4'b0000
- One sub-module: rr_arbiter_2, a combinational 2-way picker with inputs req[1:0] and prio, and output grant one-hot. The prio register stays in mem_arbiter.

Test Plan:
1. Reset, then fetch only, LATENCY=1, i_req_addr=0x0000_0010, mem_rdata=0x0040_0093 at T+2 → i_req_ready at T, mem_en and mem_addr=0x10 at T+1, i_resp_valid=1 and i_resp_data=0x0040_0093 at T+3 only.
2. Both valid on the first cycle after reset → data granted first, then fetch. Grants alternate D,I,D,I under continuous contention, with accepts every 3 cycles for LATENCY=1.
3. Store d_req_addr=0x103, wstrb=4'b1000, wdata=0xAB00_0000 → mem_addr=0x100, mem_wstrb=1000, mem_wdata=0xAB00_0000 in ISSUE; d_resp_valid pulses with d_resp_data=0.
4. LATENCY=4 load → resp_valid exactly 6 cycles after accept; mem_rdata garbage in other WAIT cycles is not captured.
5. reset asserted during WAIT → next cycle state IDLE, no resp_valid pulse, prio=DATA. A new fetch then completes normally.
6. Fetch held valid while data is in flight → i_req_ready stays 0 until the d_resp_valid cycle. Fetch is accepted in that same cycle, and the address is unchanged on mem_addr.

Source files
------------

// File: rtl/miniRV_pkg.sv
// Shared types and constants for the miniRV memory arbiter.
// No logic; no latency; no flow control.
// Imported by mem_arbiter and its picker.
package miniRV_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic       PORT_I     = 1'b0;
    localparam logic       PORT_D     = 1'b1;
    localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way picker: a lone requester wins, a tie goes to the port named by prio.
// Combinational, zero latency.
// No backpressure of its own; the caller gates the grant with its own readiness.
module rr_arbiter_2
    import miniRV_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio == PORT_D) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin share of one fixed-latency memory between fetch and load/store.
// Latency: accept at T, mem_en at T+1, resp_valid pulse at T+2+LATENCY.
// Backpressure: ready only in IDLE for the winner; one transaction in flight.
module mem_arbiter
    import miniRV_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [31:0]       i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_wstrb,
    input  logic [31:0]       d_req_wdata,
    output logic              d_resp_valid,
    output logic [31:0]       d_resp_data,
    output logic              mem_en,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    arb_state_t        state_q, state_d;
    logic              prio_q;
    logic [3:0]        cnt_q;
    logic              port_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        grant;
    logic              i_acc, d_acc;
    logic              unused_addr_lsbs;

    // Byte lane selection is the LSU's job; the low address bits are dropped.
    assign unused_addr_lsbs = ^{i_req_addr[1:0], d_req_addr[1:0]};

    rr_arbiter_2 u_pick (
        .req   ({d_req_valid, i_req_valid}),
        .prio  (prio_q),
        .grant (grant)
    );

    assign i_req_ready = (state_q == IDLE) && grant[PORT_I];
    assign d_req_ready = (state_q == IDLE) && grant[PORT_D];
    assign i_acc       = i_req_valid && i_req_ready;
    assign d_acc       = d_req_valid && d_req_ready;

    assign mem_en    = (state_q == ISSUE);
    assign mem_wstrb = mem_en ? wstrb_q : WSTRB_NONE;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_acc || d_acc) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == 4'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prio_q       <= PORT_D;
            cnt_q        <= 4'd0;
            port_q       <= PORT_I;
            we_q         <= 1'b0;
            wstrb_q      <= WSTRB_NONE;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            i_resp_data  <= 32'd0;
            d_resp_data  <= 32'd0;
        end else begin
            state_q      <= state_d;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;

            if (d_acc) begin
                port_q  <= PORT_D;
                prio_q  <= PORT_I;
                we_q    <= d_req_we;
                wstrb_q <= d_req_we ? d_req_wstrb : WSTRB_NONE;
                addr_q  <= {d_req_addr[ADDR_W-1:2], 2'b00};
                if (d_req_we) wdata_q <= d_req_wdata;
            end else if (i_acc) begin
                port_q  <= PORT_I;
                prio_q  <= PORT_D;
                we_q    <= 1'b0;
                wstrb_q <= WSTRB_NONE;
                addr_q  <= {i_req_addr[ADDR_W-1:2], 2'b00};
            end

            // Counter value 1 marks the cycle mem_rdata is valid.
            if (state_q == ISSUE) begin
                cnt_q <= LAT_INIT;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (port_q == PORT_D) begin
                        d_resp_valid <= 1'b1;
                        d_resp_data  <= we_q ? 32'd0 : mem_rdata;
                    end else begin
                        i_resp_valid <= 1'b1;
                        i_resp_data  <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=1, one at LATENCY=4,
// sharing stimulus; inputs change on negedge, outputs checked 1ns later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid, d_req_valid, d_req_we;
    logic [31:0] i_req_addr, d_req_addr, d_req_wdata, mem_rdata;
    logic [3:0]  d_req_wstrb;

    logic        i_req_ready_1, i_resp_valid_1, d_req_ready_1, d_resp_valid_1, mem_en_1;
    logic [31:0] i_resp_data_1, d_resp_data_1, mem_addr_1, mem_wdata_1;
    logic [3:0]  mem_wstrb_1;
    logic        i_req_ready_4, i_resp_valid_4, d_req_ready_4, d_resp_valid_4, mem_en_4;
    logic [31:0] i_resp_data_4, d_resp_data_4, mem_addr_4, mem_wdata_4;
    logic [3:0]  mem_wstrb_4;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(1), .ADDR_W(32)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_1), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid_1), .i_resp_data(i_resp_data_1),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_1), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid_1), .d_resp_data(d_resp_data_1),
        .mem_en(mem_en_1), .mem_wstrb(mem_wstrb_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(4), .ADDR_W(32)) u_dut4 (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_4), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid_4), .i_resp_data(i_resp_data_4),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_4), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid_4), .d_resp_data(d_resp_data_4),
        .mem_en(mem_en_4), .mem_wstrb(mem_wstrb_4), .mem_addr(mem_addr_4),
        .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic settle;
        #1;
    endtask

    // Leaves reset asserted at a negedge; the caller releases it.
    task automatic do_reset;
        tick;
        reset = 1'b1;
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        i_req_addr = 32'd0; d_req_addr = 32'd0; d_req_wstrb = 4'd0; d_req_wdata = 32'd0;
        mem_rdata = 32'hFFFF_FFFF;
        tick;
        tick;
    endtask

    // One data-port access on the LATENCY=1 instance, starting with it idle.
    task automatic d_xact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_resp);
        d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr;
        d_req_wstrb = strb; d_req_wdata = wd;
        settle;
        chk({tag, ".ready"}, 32'(d_req_ready_1), 32'd1);
        tick;
        d_req_valid = 1'b0;
        settle;
        chk({tag, ".mem_en"}, 32'(mem_en_1), 32'd1);
        chk({tag, ".mem_addr"}, mem_addr_1, exp_maddr);
        chk({tag, ".mem_wstrb"}, 32'(mem_wstrb_1), we ? 32'(strb) : 32'd0);
        if (we) chk({tag, ".mem_wdata"}, mem_wdata_1, wd);
        tick;
        mem_rdata = rd;
        settle;
        chk({tag, ".en_off"}, 32'(mem_en_1), 32'd0);
        chk({tag, ".no_early"}, 32'(d_resp_valid_1), 32'd0);
        tick;
        mem_rdata = 32'hFFFF_FFFF;
        settle;
        chk({tag, ".resp_v"}, 32'(d_resp_valid_1), 32'd1);
        chk({tag, ".resp_d"}, d_resp_data_1, exp_resp);
        tick;
        settle;
        chk({tag, ".resp_off"}, 32'(d_resp_valid_1), 32'd0);
        chk({tag, ".resp_hold"}, d_resp_data_1, exp_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and a single fetch at LATENCY=1.
        do_reset;
        settle;
        chk("rst.mem_en", 32'(mem_en_1), 32'd0);
        chk("rst.mem_wstrb", 32'(mem_wstrb_1), 32'd0);
        chk("rst.i_resp_v", 32'(i_resp_valid_1), 32'd0);
        chk("rst.d_resp_v", 32'(d_resp_valid_1), 32'd0);
        chk("rst.i_resp_d", i_resp_data_1, 32'd0);
        chk("rst.d_resp_d", d_resp_data_1, 32'd0);
        chk("rst.mem_en4", 32'(mem_en_4), 32'd0);
        tick;
        reset = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0010;
        settle;
        chk("f.i_ready", 32'(i_req_ready_1), 32'd1);
        chk("f.d_ready", 32'(d_req_ready_1), 32'd0);
        tick;
        i_req_valid = 1'b0;
        settle;
        chk("f.mem_en", 32'(mem_en_1), 32'd1);
        chk("f.mem_addr", mem_addr_1, 32'h0000_0010);
        chk("f.mem_wstrb", 32'(mem_wstrb_1), 32'd0);
        tick;
        mem_rdata = 32'h0040_0093;
        settle;
        chk("f.en_off", 32'(mem_en_1), 32'd0);
        chk("f.no_early", 32'(i_resp_valid_1), 32'd0);
        tick;
        mem_rdata = 32'hDEAD_BEEF;
        settle;
        chk("f.resp_v", 32'(i_resp_valid_1), 32'd1);
        chk("f.resp_d", i_resp_data_1, 32'h0040_0093);
        chk("f.d_resp_v", 32'(d_resp_valid_1), 32'd0);
        tick;
        settle;
        chk("f.resp_off", 32'(i_resp_valid_1), 32'd0);
        chk("f.resp_hold", i_resp_data_1, 32'h0040_0093);

        // Continuous contention from the first cycle after reset: D,I,D,I every 3 cycles.
        do_reset;
        reset = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h20;
        d_req_valid = 1'b1; d_req_addr = 32'h30; d_req_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            settle;
            chk($sformatf("rr.d_ready[%0d]", k), 32'(d_req_ready_1),
                32'((k % 3 == 0) && ((k / 3) % 2 == 0)));
            chk($sformatf("rr.i_ready[%0d]", k), 32'(i_req_ready_1),
                32'((k % 3 == 0) && ((k / 3) % 2 == 1)));
            if (k % 3 == 1)
                chk($sformatf("rr.mem_addr[%0d]", k), mem_addr_1,
                    ((k / 3) % 2 == 0) ? 32'h30 : 32'h20);
            tick;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;

        // Loads and stores on the data port.
        do_reset;
        reset = 1'b0;
        d_xact("ld", 1'b0, 32'h200, 4'b0000, 32'h0, 32'h55AA_1234, 32'h200, 32'h55AA_1234);
        d_xact("st", 1'b1, 32'h103, 4'b1000, 32'hAB00_0000, 32'h1234_5678, 32'h100, 32'h0);
        d_xact("st0", 1'b1, 32'h008, 4'b0000, 32'h0000_0001, 32'h1234_5678, 32'h008, 32'h0);

        // LATENCY=4 load: only the rdata of the final WAIT cycle is captured.
        do_reset;
        reset = 1'b0;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h40;
        settle;
        chk("l4.ready", 32'(d_req_ready_4), 32'd1);
        tick;
        d_req_valid = 1'b0;
        settle;
        chk("l4.mem_en", 32'(mem_en_4), 32'd1);
        chk("l4.mem_addr", mem_addr_4, 32'h40);
        for (int k = 2; k <= 5; k++) begin
            tick;
            mem_rdata = (k == 5) ? 32'hCAFE_F00D : (32'hBAD0_0000 | 32'(k));
            settle;
            chk($sformatf("l4.no_resp[%0d]", k), 32'(d_resp_valid_4), 32'd0);
        end
        tick;
        mem_rdata = 32'h0BAD_0BAD;
        settle;
        chk("l4.resp_v", 32'(d_resp_valid_4), 32'd1);
        chk("l4.resp_d", d_resp_data_4, 32'hCAFE_F00D);
        tick;
        settle;
        chk("l4.resp_off", 32'(d_resp_valid_4), 32'd0);

        // Reset during WAIT aborts; prio back to DATA; then a clean fetch.
        do_reset;
        reset = 1'b0;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h40;
        settle;
        chk("ab.ready", 32'(d_req_ready_4), 32'd1);
        tick;
        d_req_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        mem_rdata = 32'h9999_9999;
        i_req_valid = 1'b1; i_req_addr = 32'h80;
        d_req_valid = 1'b1;
        settle;
        chk("ab.no_resp", 32'(d_resp_valid_4), 32'd0);
        chk("ab.mem_en", 32'(mem_en_4), 32'd0);
        chk("ab.prio_d", 32'(d_req_ready_4), 32'd1);
        chk("ab.prio_i", 32'(i_req_ready_4), 32'd0);
        tick;
        reset = 1'b0;
        d_req_valid = 1'b0;
        settle;
        chk("ab.i_ready", 32'(i_req_ready_4), 32'd1);
        chk("ab.no_resp2", 32'(d_resp_valid_4), 32'd0);
        chk("ab.d_data", d_resp_data_4, 32'd0);
        tick;
        i_req_valid = 1'b0;
        settle;
        chk("ab.f_en", 32'(mem_en_4), 32'd1);
        chk("ab.f_addr", mem_addr_4, 32'h80);
        for (int k = 6; k <= 9; k++) begin
            tick;
            mem_rdata = (k == 9) ? 32'h1122_3344 : 32'h7777_0000;
            settle;
            chk($sformatf("ab.no_iresp[%0d]", k), 32'(i_resp_valid_4), 32'd0);
        end
        tick;
        mem_rdata = 32'hFFFF_FFFF;
        settle;
        chk("ab.f_resp_v", 32'(i_resp_valid_4), 32'd1);
        chk("ab.f_resp_d", i_resp_data_4, 32'h1122_3344);
        chk("ab.d_silent", 32'(d_resp_valid_4), 32'd0);

        // Fetch held while data is in flight: accepted in the d_resp_valid cycle.
        do_reset;
        reset = 1'b0;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h300;
        i_req_valid = 1'b1; i_req_addr = 32'h44;
        settle;
        chk("hold.d_ready", 32'(d_req_ready_1), 32'd1);
        chk("hold.i_ready0", 32'(i_req_ready_1), 32'd0);
        tick;
        d_req_valid = 1'b0;
        settle;
        chk("hold.i_ready1", 32'(i_req_ready_1), 32'd0);
        chk("hold.d_addr", mem_addr_1, 32'h300);
        tick;
        mem_rdata = 32'h0000_0077;
        settle;
        chk("hold.i_ready2", 32'(i_req_ready_1), 32'd0);
        tick;
        mem_rdata = 32'hFFFF_FFFF;
        settle;
        chk("hold.d_resp_v", 32'(d_resp_valid_1), 32'd1);
        chk("hold.d_resp_d", d_resp_data_1, 32'h0000_0077);
        chk("hold.i_ready3", 32'(i_req_ready_1), 32'd1);
        tick;
        i_req_valid = 1'b0;
        settle;
        chk("hold.i_en", 32'(mem_en_1), 32'd1);
        chk("hold.i_addr", mem_addr_1, 32'h44);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
